fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of a FIFO among NUM_REQ requesters.
- Grants one requester at a time for a bounded burst.
- Drives the FIFO's write enable and write data directly.
- Never writes while the FIFO reports full, so the FIFO's write-error flag cannot be raised through this block.
- Sits in the FIFO's write-clock domain, between the producer blocks and the FIFO write side.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producer lanes, the arbiter and the FIFO write port.
// The master modport is the arbiter; the slave modport is the producer/FIFO environment.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int OWN_W   = 2
);
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     fifo_full_i;
  logic                     fifo_wr_en_o;
  logic [WIDTH-1:0]         fifo_wdata_o;
  logic                     busy_o;
  logic [OWN_W-1:0]         owner_o;

  modport master (
    input  req_i, wdata_i, fifo_full_i,
    output gnt_o, fifo_wr_en_o, fifo_wdata_o, busy_o, owner_o
  );

  modport slave (
    output req_i, wdata_i, fifo_full_i,
    input  gnt_o, fifo_wr_en_o, fifo_wdata_o, busy_o, owner_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants bounded bursts and never writes while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int OWN_W     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fifo_wr_arbiter_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [7:0]       LAST_CNT  = 8'(MAX_BURST - 1);
  localparam logic [OWN_W-1:0] LAST_INIT = OWN_W'(NUM_REQ - 1);

  state_t           state_reg, state_next;
  logic [OWN_W-1:0] owner_reg, owner_next;
  logic [OWN_W-1:0] last_reg, last_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [OWN_W-1:0] sel;
  logic             found;
  logic             accept;
  int               idx;
  logic [WIDTH-1:0] lane [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane[gi] = bus.wdata_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search starts one past the most recent owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    sel   = last_reg;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_reg) + i) % NUM_REQ;
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        sel   = OWN_W'(idx);
      end
    end
  end

  assign accept = (state_reg == BURST) && bus.req_i[owner_reg]
                  && !bus.fifo_full_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= LAST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          owner_next = sel;
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          if (cnt_reg == LAST_CNT) begin
            cnt_next   = '0;
            last_next  = owner_reg;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end else if (!bus.req_i[owner_reg]) begin
          // Owner released the burst early.
          last_next  = owner_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_o        = '0;
    bus.fifo_wr_en_o = 1'b0;
    bus.fifo_wdata_o = '0;
    if (accept) begin
      bus.gnt_o[owner_reg] = 1'b1;
      bus.fifo_wr_en_o     = 1'b1;
      bus.fifo_wdata_o     = lane[owner_reg];
    end
  end

  assign bus.busy_o  = (state_reg == BURST);
  assign bus.owner_o = owner_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Cycle-table bench for fifo_wr_arbiter: per-cycle expected outputs plus a
// scoreboard of expected FIFO words popped whenever the arbiter writes.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int OWN_W     = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .OWN_W(OWN_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .OWN_W(OWN_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        full;
    logic [31:0] lanes;
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  wd;
    logic        busy;
    logic [1:0]  owner;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [31:0] mk(int k, logic [7:0] val);
    logic [31:0] l;
    l = 32'hEEEE_EEEE;
    l[k*8 +: 8] = val;
    return l;
  endfunction

  function automatic void add(logic r, logic [3:0] rq, logic f, logic [31:0] ln,
                              logic [3:0] g, logic w, logic [7:0] d, logic b, logic [1:0] o);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.lanes = ln;
    v.gnt = g; v.wr = w; v.wd = d; v.busy = b; v.owner = o;
    vecs.push_back(v);
  endfunction

  function automatic void idle_v(logic [3:0] rq, logic [31:0] ln, logic [1:0] o);
    add(1'b0, rq, 1'b0, ln, 4'h0, 1'b0, 8'h00, 1'b0, o);
  endfunction

  function automatic void wr_v(logic [3:0] rq, logic [31:0] ln, logic [1:0] o, logic [7:0] d);
    add(1'b0, rq, 1'b0, ln, 4'b0001 << o, 1'b1, d, 1'b1, o);
  endfunction

  function automatic void fill();
    logic [31:0] la;
    logic [31:0] lb;
    la = 32'hA3A2_A1A0;
    lb = 32'h73EE_71EE;
    // Reset with everyone requesting, then fairness rotation 0,1,2,3,0
    for (int k = 0; k < 3; k++) add(1'b1, 4'hF, 1'b0, la, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    idle_v(4'hF, la, 2'd0);
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) wr_v(4'hF, la, 2'(b % 4), 8'(8'hA0 + b % 4));
      if (b < 4) idle_v(4'hF, la, 2'(b % 4));
    end
    // Single requester 2: 4 writes, idle, 4, idle, 2, then release
    for (int w = 0; w < 10; w++) begin
      if (w % 4 == 0) idle_v(4'h4, mk(2, 8'(16 + w)), (w == 0) ? 2'd0 : 2'd2);
      wr_v(4'h4, mk(2, 8'(16 + w)), 2'd2, 8'(16 + w));
    end
    add(1'b0, 4'h0, 1'b0, mk(2, 8'h1A), 4'h0, 1'b0, 8'h00, 1'b1, 2'd2);
    // Full stall on requester 1 at its 3rd word
    idle_v(4'h2, mk(1, 8'h30), 2'd2);
    wr_v(4'h2, mk(1, 8'h30), 2'd1, 8'h30);
    wr_v(4'h2, mk(1, 8'h31), 2'd1, 8'h31);
    for (int k = 0; k < 3; k++) add(1'b0, 4'h2, 1'b1, mk(1, 8'h32), 4'h0, 1'b0, 8'h00, 1'b1, 2'd1);
    wr_v(4'h2, mk(1, 8'h32), 2'd1, 8'h32);
    wr_v(4'h2, mk(1, 8'h33), 2'd1, 8'h33);
    // Early release by requester 3 while requester 0 waits
    idle_v(4'h9, mk(3, 8'h40), 2'd1);
    wr_v(4'h9, mk(3, 8'h40), 2'd3, 8'h40);
    wr_v(4'h9, mk(3, 8'h41), 2'd3, 8'h41);
    add(1'b0, 4'h1, 1'b0, mk(0, 8'h50), 4'h0, 1'b0, 8'h00, 1'b1, 2'd3);
    idle_v(4'h1, mk(0, 8'h50), 2'd3);
    wr_v(4'h1, mk(0, 8'h50), 2'd0, 8'h50);
    add(1'b0, 4'h0, 1'b0, mk(0, 8'h51), 4'h0, 1'b0, 8'h00, 1'b1, 2'd0);
    // Reset during requester 2's second word
    idle_v(4'h4, mk(2, 8'h60), 2'd0);
    wr_v(4'h4, mk(2, 8'h60), 2'd2, 8'h60);
    add(1'b1, 4'h4, 1'b0, mk(2, 8'h61), 4'h0, 1'b0, 8'h00, 1'b1, 2'd2);
    add(1'b1, 4'h4, 1'b0, mk(2, 8'h61), 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    idle_v(4'hA, lb, 2'd0);
    wr_v(4'hA, lb, 2'd1, 8'h71);
    add(1'b0, 4'h0, 1'b0, lb, 4'h0, 1'b0, 8'h00, 1'b1, 2'd1);
    idle_v(4'h0, lb, 2'd1);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, expv);
    end
  endtask

  initial begin
    logic [7:0] d;
    rst             = 1'b1;
    bus.req_i       = '0;
    bus.wdata_i     = '0;
    bus.fifo_full_i = 1'b0;
    fill();
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst             = vecs[i].rst;
      bus.req_i       = vecs[i].req;
      bus.fifo_full_i = vecs[i].full;
      bus.wdata_i     = vecs[i].lanes;
      if (vecs[i].wr) exp_q.push_back(vecs[i].wd);
      #1;
      chk("gnt",   i, 32'(bus.gnt_o),        32'(vecs[i].gnt));
      chk("wr_en", i, 32'(bus.fifo_wr_en_o), 32'(vecs[i].wr));
      chk("wdata", i, 32'(bus.fifo_wdata_o), 32'(vecs[i].wd));
      chk("busy",  i, 32'(bus.busy_o),       32'(vecs[i].busy));
      chk("owner", i, 32'(bus.owner_o),      32'(vecs[i].owner));
      chk("write_while_full", i, 32'(bus.fifo_wr_en_o & bus.fifo_full_i), 32'd0);
      if (bus.fifo_wr_en_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard vec %0d: got write %02h expected no write", i, bus.fifo_wdata_o);
        end else begin
          d = exp_q.pop_front();
          chk("sb_data", i, 32'(bus.fifo_wdata_o), 32'(d));
          $display("vec %0d: write owner %0d data %02h", i, bus.owner_o, bus.fifo_wdata_o);
        end
      end
    end
    chk("sb_empty", vecs.size(), 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
